bias_pingpong_buffer: RTL and testbench
=======================================

BIAS_PINGPONG_BUFFER -- requirements
Module: bias_pingpong_buffer

Interface
REQ-001 SHALL have parameter NUM_CH, default K_CHANNELS, bias lanes per entry.
REQ-002 SHALL have parameter DATA_W, default ACC_WIDTH, bits per lane.
REQ-003 SHALL have parameter DEPTH, default 64, entries per bank; any value >= 2, not required to be a power of two.
REQ-004 SHALL have parameter ADDR_W, default $clog2(DEPTH), address width.
REQ-005 SHALL use one clock and an asynchronous active-high reset: clk_i in 1, rising-edge clock; rst_async_i in 1, async active-high reset.
REQ-006 SHALL have loader inputs: ld_valid_i in 1, write request; ld_addr_i in ADDR_W, entry index; ld_ch_mask_i in NUM_CH, per-lane write enable; ld_data_i in NUM_CH x DATA_W, lane data; ld_last_i in 1, final write of bank image.
REQ-007 SHALL have loader output ld_ready_o out 1, shadow bank accepts writes.
REQ-008 SHALL have swap ports: swap_req_i in 1, request bank exchange; swap_ack_o out 1, one-cycle pulse on exchange.
REQ-009 SHALL have status outputs: active_bank_o out 1, bank index read by compute; active_valid_o out 1, active bank holds a committed image; shadow_full_o out 1, shadow bank committed; err_o out 1, sticky error.
REQ-010 SHALL have read ports: rd_en_i in 1; rd_addr_i in ADDR_W; rd_valid_o out 1; rd_data_o out NUM_CH x DATA_W.

Function
REQ-011 SHALL hold two banks of DEPTH x NUM_CH x DATA_W; loader writes only the shadow bank (index !active_bank_o); reads only the active bank.
REQ-012 SHALL accept a write when ld_valid_i && ld_ready_o; only lanes with ld_ch_mask_i[c]=1 update, other lanes keep prior value.
REQ-013 SHALL run a shadow FSM with states EMPTY, FILLING, FULL: EMPTY->FILLING on accepted write without last; EMPTY/FILLING->FULL on accepted write with ld_last_i; FULL->EMPTY on swap.
REQ-014 SHALL drive ld_ready_o = (shadow state != FULL); shadow_full_o = (state == FULL).
REQ-015 SHALL latch swap_req_i into a sticky pending flag; swap occurs on the first edge where pending (or swap_req_i) && state==FULL.
REQ-016 SHALL on swap toggle active_bank_o, set active_valid_o=1, set shadow state EMPTY, clear pending, and pulse swap_ack_o for exactly the following cycle.
REQ-017 SHALL, when swap and a FULL-completing write coincide, accept the write first; swap occurs no earlier than the next edge.
REQ-018 SHALL register reads: rd_en_i at edge N gives rd_valid_o=1 and rd_data_o=active[rd_addr_i] after edge N, bank sampled at edge N (pre-swap bank if swap at same edge).
REQ-019 SHALL hold rd_data_o when rd_en_i=0; rd_valid_o=0 that cycle.
REQ-020 SHALL return all-zero rd_data_o and set err_o for a read when active_valid_o=0 or rd_addr_i >= DEPTH.
REQ-021 SHALL drop an accepted write with ld_addr_i >= DEPTH (no state change except FSM on ld_last_i) and set err_o.
REQ-022 SHALL allow simultaneous read and write every cycle (separate banks, no hazard).
REQ-023 SHALL not clear err_o except by reset.

Reset
REQ-024 SHALL on rst_async_i=1 immediately set active_bank_o=0, active_valid_o=0, shadow state EMPTY, pending=0, swap_ack_o=0, rd_valid_o=0, rd_data_o=0, err_o=0; ld_ready_o=1 after reset.
REQ-025 SHALL not reset memory contents; reset mid-fill discards the partial image logically (state EMPTY).

Structure
REQ-026 SHALL take K_CHANNELS and ACC_WIDTH defaults from the shared definitions package; FSM state enum SHALL live in that package.
REQ-027 SHALL instantiate one sub-module bias_bank (single bank, lane-masked write, registered read) twice.

Verification
REQ-028 Load bank1 addr 0..3 data=addr+1 on all lanes, last on addr 3, swap_req -> swap_ack one cycle later, active_bank_o=1, read addr 2 returns 3 on all lanes one cycle after rd_en.
REQ-029 Swap_req asserted while FILLING, 5 cycles later write with last -> no ack before FULL; ack exactly 2 cycles after last write edge.
REQ-030 Write addr 5 mask=0b0001 data 0xAA after full write 0x11 -> lane0=0xAA, other lanes 0x11.
REQ-031 Read addr 1 at same edge as swap -> data from old bank; next read from new bank.
REQ-032 Read before any swap, or write to addr DEPTH (DEPTH=48) -> zero data / write dropped, err_o=1 sticky until reset.
REQ-033 Assert rst_async_i mid-fill between clock edges -> outputs reset values immediately, ld_ready_o=1, active_valid_o=0.

Source files
------------

// File: rtl/bias_pingpong_buffer_pkg.sv
// Shared definitions for the bias ping-pong buffer: lane geometry defaults
// and the shadow-bank fill state encoding.
package bias_pingpong_buffer_pkg;

    localparam int K_CHANNELS = 4;
    localparam int ACC_WIDTH  = 32;

    typedef enum logic [1:0] {
        SH_EMPTY   = 2'd0,
        SH_FILLING = 2'd1,
        SH_FULL    = 2'd2
    } shadow_state_t;

endpackage

// File: rtl/bias_pingpong_buffer_bank.sv
// Single bias bank: DEPTH entries of NUM_CH lanes, lane-masked write port and
// a registered read port that holds its value while re is low.
module bias_bank #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [ADDR_W-1:0]              waddr,
    input  logic [NUM_CH-1:0]              wmask,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  wdata,
    input  logic                           re,
    input  logic [ADDR_W-1:0]              raddr,
    output logic [NUM_CH-1:0][DATA_W-1:0]  rdata
);

    // Storage is deliberately not reset; callers only ever address it in range.
    logic [NUM_CH-1:0][DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (we && wmask[c]) begin
                mem[waddr][c] <= wdata[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bias_pingpong_buffer.sv
// Double-buffered bias store: the loader fills the shadow bank while compute
// reads the active bank; a committed shadow image is swapped in on request.
module bias_pingpong_buffer
    import bias_pingpong_buffer_pkg::*;
#(
    parameter int NUM_CH = K_CHANNELS,
    parameter int DATA_W = ACC_WIDTH,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                           clk_i,
    input  logic                           rst_async_i,
    input  logic                           ld_valid_i,
    input  logic [ADDR_W-1:0]              ld_addr_i,
    input  logic [NUM_CH-1:0]              ld_ch_mask_i,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  ld_data_i,
    input  logic                           ld_last_i,
    output logic                           ld_ready_o,
    input  logic                           swap_req_i,
    output logic                           swap_ack_o,
    output logic                           active_bank_o,
    output logic                           active_valid_o,
    output logic                           shadow_full_o,
    output logic                           err_o,
    input  logic                           rd_en_i,
    input  logic [ADDR_W-1:0]              rd_addr_i,
    output logic                           rd_valid_o,
    output logic [NUM_CH-1:0][DATA_W-1:0]  rd_data_o
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    shadow_state_t state_q, state_d;
    logic          pending_q, pending_d;
    logic          swap_fire;
    logic          ack_q;
    logic          active_bank_q;
    logic          active_valid_q;
    logic          err_q;

    logic          write_acc, wr_addr_ok, wr_commit;
    logic          rd_addr_ok, rd_ok;

    logic          rd_valid_q;
    logic          rd_sel_q;
    logic          rd_zero_q;

    logic [1:0]                      bank_we;
    logic [1:0]                      bank_re;
    logic [NUM_CH-1:0][DATA_W-1:0]   bank_rdata [2];

    assign ld_ready_o = (state_q != SH_FULL);
    assign write_acc  = ld_valid_i && ld_ready_o;
    assign wr_addr_ok = ({1'b0, ld_addr_i} < DEPTH_LIM);
    assign wr_commit  = write_acc && wr_addr_ok;
    assign rd_addr_ok = ({1'b0, rd_addr_i} < DEPTH_LIM);
    assign rd_ok      = rd_en_i && active_valid_q && rd_addr_ok;

    // Shadow is always the bank compute is not reading.
    assign bank_we[0] = wr_commit & active_bank_q;
    assign bank_we[1] = wr_commit & ~active_bank_q;
    assign bank_re[0] = rd_ok & ~active_bank_q;
    assign bank_re[1] = rd_ok & active_bank_q;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        bias_bank #(
            .NUM_CH (NUM_CH),
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk    (clk_i),
            .we     (bank_we[b]),
            .waddr  (ld_addr_i),
            .wmask  (ld_ch_mask_i),
            .wdata  (ld_data_i),
            .re     (bank_re[b]),
            .raddr  (rd_addr_i),
            .rdata  (bank_rdata[b])
        );
    end

    // A swap can only fire from FULL, where writes are refused, so a
    // FULL-completing write always lands at least one edge before its swap.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | swap_req_i;
        swap_fire = 1'b0;
        case (state_q)
            SH_EMPTY: begin
                if (write_acc) begin
                    if (ld_last_i) begin
                        state_d = SH_FULL;
                    end else if (wr_addr_ok) begin
                        state_d = SH_FILLING;
                    end
                end
            end
            SH_FILLING: begin
                if (write_acc && ld_last_i) begin
                    state_d = SH_FULL;
                end
            end
            SH_FULL: begin
                if (pending_q || swap_req_i) begin
                    swap_fire = 1'b1;
                    state_d   = SH_EMPTY;
                    pending_d = 1'b0;
                end
            end
            default: state_d = SH_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_async_i) begin
        if (rst_async_i) begin
            state_q        <= SH_EMPTY;
            pending_q      <= 1'b0;
            ack_q          <= 1'b0;
            active_bank_q  <= 1'b0;
            active_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ack_q     <= swap_fire;
            if (swap_fire) begin
                active_bank_q  <= ~active_bank_q;
                active_valid_q <= 1'b1;
            end
            if ((write_acc && !wr_addr_ok) || (rd_en_i && !rd_ok)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Bank select and zero flag are captured with the read so the output
    // holds steady across swaps and idle cycles.
    always_ff @(posedge clk_i or posedge rst_async_i) begin
        if (rst_async_i) begin
            rd_valid_q <= 1'b0;
            rd_sel_q   <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else begin
            rd_valid_q <= rd_en_i;
            if (rd_en_i) begin
                rd_sel_q  <= active_bank_q;
                rd_zero_q <= !rd_ok;
            end
        end
    end

    assign rd_data_o      = rd_zero_q ? '0 : bank_rdata[rd_sel_q];
    assign rd_valid_o     = rd_valid_q;
    assign swap_ack_o     = ack_q;
    assign active_bank_o  = active_bank_q;
    assign active_valid_o = active_valid_q;
    assign shadow_full_o  = (state_q == SH_FULL);
    assign err_o          = err_q;

endmodule

// File: tb/tb_bias_pingpong_buffer.sv
// Directed self-checking bench for bias_pingpong_buffer (DEPTH=48, 4 lanes x 32 bits).
module tb_bias_pingpong_buffer;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 48;
    localparam int ADDR_W = 6;

    logic                           clk;
    logic                           rst;
    logic                           ld_valid;
    logic [ADDR_W-1:0]              ld_addr;
    logic [NUM_CH-1:0]              ld_ch_mask;
    logic [NUM_CH-1:0][DATA_W-1:0]  ld_data;
    logic                           ld_last;
    logic                           ld_ready;
    logic                           swap_req;
    logic                           swap_ack;
    logic                           active_bank;
    logic                           active_valid;
    logic                           shadow_full;
    logic                           err;
    logic                           rd_en;
    logic [ADDR_W-1:0]              rd_addr;
    logic                           rd_valid;
    logic [NUM_CH-1:0][DATA_W-1:0]  rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    bias_pingpong_buffer #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_i          (clk),
        .rst_async_i    (rst),
        .ld_valid_i     (ld_valid),
        .ld_addr_i      (ld_addr),
        .ld_ch_mask_i   (ld_ch_mask),
        .ld_data_i      (ld_data),
        .ld_last_i      (ld_last),
        .ld_ready_o     (ld_ready),
        .swap_req_i     (swap_req),
        .swap_ack_o     (swap_ack),
        .active_bank_o  (active_bank),
        .active_valid_o (active_valid),
        .shadow_full_o  (shadow_full),
        .err_o          (err),
        .rd_en_i        (rd_en),
        .rd_addr_i      (rd_addr),
        .rd_valid_o     (rd_valid),
        .rd_data_o      (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [NUM_CH-1:0] m,
                            input logic [NUM_CH-1:0][DATA_W-1:0] d, input logic last);
        ld_valid   = 1'b1;
        ld_addr    = a;
        ld_ch_mask = m;
        ld_data    = d;
        ld_last    = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        rd_en = 1'b0;
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        n_checks++; if (active_bank !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_active_bank: got %0b want 0", active_bank); end
        n_checks++; if (active_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_active_valid: got %0b want 0", active_valid); end
        n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ld_ready: got %0b want 1", ld_ready); end
        n_checks++; if (shadow_full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_shadow_full: got %0b want 0", shadow_full); end
        n_checks++; if (swap_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_swap_ack: got %0b want 0", swap_ack); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd_valid: got %0b want 0", rd_valid); end
        n_checks++; if (rd_data !== '0) begin n_fail++; $display("[TB] FAIL reset_rd_data: got %h want 0", rd_data); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %0b want 0", err); end
    endtask

    task automatic test_read_before_swap();
        do_read(6'd0);
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL noswap_rd_valid: got %0b want 1", rd_valid); end
        n_checks++; if (rd_data !== '0) begin n_fail++; $display("[TB] FAIL noswap_rd_data: got %h want 0", rd_data); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL noswap_err: got %0b want 1", err); end
        step();
        step();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL noswap_err_sticky: got %0b want 1", err); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL noswap_rd_valid_idle: got %0b want 0", rd_valid); end
        apply_reset();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL noswap_err_cleared: got %0b want 0", err); end
    endtask

    task automatic test_load_swap();
        for (int a = 0; a < 4; a++) begin
            do_write(6'(a), 4'hF, {4{32'(a + 1)}}, (a == 3));
        end
        n_checks++; if (shadow_full !== 1'b1) begin n_fail++; $display("[TB] FAIL load_shadow_full: got %0b want 1", shadow_full); end
        n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL load_ld_ready: got %0b want 0", ld_ready); end
        n_checks++; if (swap_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL load_ack_early: got %0b want 0", swap_ack); end
        do_swap();
        n_checks++; if (swap_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL load_swap_ack: got %0b want 1", swap_ack); end
        n_checks++; if (active_bank !== 1'b1) begin n_fail++; $display("[TB] FAIL load_active_bank: got %0b want 1", active_bank); end
        n_checks++; if (active_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL load_active_valid: got %0b want 1", active_valid); end
        n_checks++; if (shadow_full !== 1'b0) begin n_fail++; $display("[TB] FAIL load_shadow_empty: got %0b want 0", shadow_full); end
        step();
        n_checks++; if (swap_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL load_ack_one_cycle: got %0b want 0", swap_ack); end
        do_read(6'd2);
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL load_rd_valid: got %0b want 1", rd_valid); end
        n_checks++; if (rd_data !== {4{32'd3}}) begin n_fail++; $display("[TB] FAIL load_rd_data: got %h want %h", rd_data, {4{32'd3}}); end
        step();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL load_rd_valid_idle: got %0b want 0", rd_valid); end
        n_checks++; if (rd_data !== {4{32'd3}}) begin n_fail++; $display("[TB] FAIL load_rd_hold: got %h want %h", rd_data, {4{32'd3}}); end
    endtask

    task automatic test_pending_swap();
        do_write(6'd0, 4'hF, {4{32'h100}}, 1'b0);
        do_swap();
        n_checks++; if (swap_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL pend_ack_filling: got %0b want 0", swap_ack); end
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (swap_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL pend_ack_wait%0d: got %0b want 0", i, swap_ack); end
        end
        do_write(6'd1, 4'hF, {4{32'h200}}, 1'b1);
        n_checks++; if (swap_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL pend_ack_at_last: got %0b want 0", swap_ack); end
        n_checks++; if (shadow_full !== 1'b1) begin n_fail++; $display("[TB] FAIL pend_shadow_full: got %0b want 1", shadow_full); end
        step();
        n_checks++; if (swap_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL pend_swap_ack: got %0b want 1", swap_ack); end
        n_checks++; if (active_bank !== 1'b0) begin n_fail++; $display("[TB] FAIL pend_active_bank: got %0b want 0", active_bank); end
        step();
        n_checks++; if (swap_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL pend_ack_one_cycle: got %0b want 0", swap_ack); end
        do_read(6'd0);
        n_checks++; if (rd_data !== {4{32'h100}}) begin n_fail++; $display("[TB] FAIL pend_rd_data: got %h want %h", rd_data, {4{32'h100}}); end
    endtask

    task automatic test_lane_mask();
        do_write(6'd5, 4'hF, {4{32'h11}}, 1'b0);
        do_write(6'd5, 4'b0001, {4{32'hAA}}, 1'b1);
        do_swap();
        n_checks++; if (active_bank !== 1'b1) begin n_fail++; $display("[TB] FAIL mask_active_bank: got %0b want 1", active_bank); end
        do_read(6'd5);
        n_checks++; if (rd_data !== {32'h11, 32'h11, 32'h11, 32'hAA}) begin n_fail++; $display("[TB] FAIL mask_rd_data: got %h want %h", rd_data, {32'h11, 32'h11, 32'h11, 32'hAA}); end
        do_read(6'd2);
        n_checks++; if (rd_data !== {4{32'd3}}) begin n_fail++; $display("[TB] FAIL mask_old_entry: got %h want %h", rd_data, {4{32'd3}}); end
    endtask

    task automatic test_read_at_swap();
        do_write(6'd1, 4'hF, {4{32'h77}}, 1'b1);
        swap_req = 1'b1;
        rd_en    = 1'b1;
        rd_addr  = 6'd1;
        step();
        swap_req = 1'b0;
        n_checks++; if (swap_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL rsw_swap_ack: got %0b want 1", swap_ack); end
        n_checks++; if (active_bank !== 1'b0) begin n_fail++; $display("[TB] FAIL rsw_active_bank: got %0b want 0", active_bank); end
        n_checks++; if (rd_data !== {4{32'd2}}) begin n_fail++; $display("[TB] FAIL rsw_old_bank: got %h want %h", rd_data, {4{32'd2}}); end
        step();
        rd_en = 1'b0;
        n_checks++; if (rd_data !== {4{32'h77}}) begin n_fail++; $display("[TB] FAIL rsw_new_bank: got %h want %h", rd_data, {4{32'h77}}); end
    endtask

    task automatic test_errors();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL errs_clean: got %0b want 0", err); end
        do_read(6'd48);
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL errs_oob_rd_valid: got %0b want 1", rd_valid); end
        n_checks++; if (rd_data !== '0) begin n_fail++; $display("[TB] FAIL errs_oob_rd_data: got %h want 0", rd_data); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL errs_oob_read_err: got %0b want 1", err); end
        do_write(6'd48, 4'hF, {4{32'hDEAD}}, 1'b1);
        n_checks++; if (shadow_full !== 1'b1) begin n_fail++; $display("[TB] FAIL errs_oob_last_full: got %0b want 1", shadow_full); end
        do_swap();
        n_checks++; if (active_bank !== 1'b1) begin n_fail++; $display("[TB] FAIL errs_active_bank: got %0b want 1", active_bank); end
        do_read(6'd5);
        n_checks++; if (rd_data !== {32'h11, 32'h11, 32'h11, 32'hAA}) begin n_fail++; $display("[TB] FAIL errs_bank_intact: got %h want %h", rd_data, {32'h11, 32'h11, 32'h11, 32'hAA}); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL errs_sticky: got %0b want 1", err); end
    endtask

    task automatic test_async_reset_midfill();
        ld_valid   = 1'b1;
        ld_addr    = 6'd0;
        ld_ch_mask = 4'hF;
        ld_data    = {4{32'h5}};
        ld_last    = 1'b0;
        rd_en      = 1'b1;
        rd_addr    = 6'd2;
        step();
        ld_valid = 1'b0;
        rd_en    = 1'b0;
        n_checks++; if (rd_data !== {4{32'd3}}) begin n_fail++; $display("[TB] FAIL midfill_concurrent_read: got %h want %h", rd_data, {4{32'd3}}); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (active_bank !== 1'b0) begin n_fail++; $display("[TB] FAIL midfill_active_bank: got %0b want 0", active_bank); end
        n_checks++; if (active_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midfill_active_valid: got %0b want 0", active_valid); end
        n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midfill_ld_ready: got %0b want 1", ld_ready); end
        n_checks++; if (rd_data !== '0) begin n_fail++; $display("[TB] FAIL midfill_rd_data: got %h want 0", rd_data); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL midfill_err: got %0b want 0", err); end
        n_checks++; if (shadow_full !== 1'b0) begin n_fail++; $display("[TB] FAIL midfill_shadow_full: got %0b want 0", shadow_full); end
        @(negedge clk);
        rst = 1'b0;
        step();
        n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midfill_ready_after: got %0b want 1", ld_ready); end
        n_checks++; if (active_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midfill_valid_after: got %0b want 0", active_valid); end
    endtask

    initial begin
        rst        = 1'b0;
        ld_valid   = 1'b0;
        ld_addr    = '0;
        ld_ch_mask = '0;
        ld_data    = '0;
        ld_last    = 1'b0;
        swap_req   = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        #1;
        rst = 1'b1;
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        step();
        test_read_before_swap();
        test_load_swap();
        test_pending_swap();
        test_lane_mask();
        test_read_at_swap();
        test_errors();
        test_async_reset_midfill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
